// File: rtl/bf16_mul_pkg.sv
// Shared types and constants for the approximate BF16 multiplier datapath.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bf16_mul_pkg;

    localparam int EXP_BIAS    = 127;
    localparam int EXP_MAX     = 255;
    localparam int BF16_FRAC_W = 7;

    // Retained fraction precision, encoded as carried on in_prec.
    typedef enum logic [1:0] {
        PREC_7 = 2'd0,
        PREC_5 = 2'd1,
        PREC_3 = 2'd2,
        PREC_1 = 2'd3
    } prec_t;

    typedef struct packed {
        logic ovf;
        logic unf;
        logic inx;
    } flags_t;

    // Number of fraction bits kept for a given precision code.
    function automatic logic [2:0] frac_keep(input prec_t prec);
        logic [2:0] k;
        case (prec)
            PREC_7:  k = 3'd7;
            PREC_5:  k = 3'd5;
            PREC_3:  k = 3'd3;
            default: k = 3'd1;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/bf16_norm_round_pipe_lzc.sv
// Leading-zero counter: number of zeros above the most significant set bit.
// Latency: combinational.
// Backpressure: none (pure function of din).
// Ports: din (W bits), cnt (leading zeros, W when din is zero), zero (din == 0).
module lzc #(
    parameter int W     = 16,
    parameter int CNT_W = $clog2(W + 1)
) (
    input  logic [W-1:0]     din,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    // Scan upward; the last set bit seen is the most significant one.
    always_comb begin
        cnt = CNT_W'(W);
        for (int i = 0; i < W; i++) begin
            if (din[i]) begin
                cnt = CNT_W'(W - 1 - i);
            end
        end
    end

    assign zero = ~|din;

endmodule

// File: rtl/bf16_norm_round_pipe.sv
// Normalize, round and pack a raw mantissa product into BF16 with flags.
// Latency: 2 cycles from accepted input to out_valid; one beat per cycle.
// Backpressure: each stage loads when empty or draining; in_ready is combinational from out_ready.
// Ports: clk, rst_n (async active-low); in_valid/in_ready with in_sign, in_exp (signed,
//   biased), in_mant (raw product), in_prec (0..3 -> 7/5/3/1 fraction bits);
//   out_valid/out_ready with out_bf16 {sign,exp,frac} and out_flags {ovf,unf,inx}.
// Build option: define ROUND_RNE_EN for round-to-nearest-even; otherwise truncate.
module bf16_norm_round_pipe
    import bf16_mul_pkg::*;
#(
    parameter int PROD_W = 17,
    parameter int EXP_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [PROD_W-1:0] in_mant,
    input  logic [1:0]        in_prec,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_bf16,
    output logic [2:0]        out_flags
);

    localparam int NW = PROD_W - 2;        // bits below the hidden one
    localparam int FW = PROD_W - 1;        // bits below hidden plus sticky
    localparam int CW = $clog2(PROD_W);
    localparam int XW = EXP_W + 2;         // headroom for +1 / -lz / +carry
    localparam logic [FW-1:0]        ONE_F     = FW'(1);
    localparam logic [BF16_FRAC_W-1:0] ONE_R   = BF16_FRAC_W'(1);
    localparam logic signed [XW-1:0] EXP_MAX_X = XW'(EXP_MAX);
    localparam logic signed [XW-1:0] ZERO_X    = '0;

    // ---------------- stage 1: normalize ----------------
    logic [CW-1:0]        lz;
    logic                 lz_zero;
    logic [NW-1:0]        n_frac;
    logic                 n_sticky;
    logic signed [XW-1:0] exp_x;
    logic signed [XW-1:0] n_exp;
    logic                 n_zero;

    lzc #(.W(PROD_W - 1), .CNT_W(CW)) u_lzc (
        .din  (in_mant[PROD_W-2:0]),
        .cnt  (lz),
        .zero (lz_zero)
    );

    assign exp_x  = {{2{in_exp[EXP_W-1]}}, in_exp};
    // The overflow bit alone still makes a nonzero product.
    assign n_zero = lz_zero & ~in_mant[PROD_W-1];

    // Only the bits below the leading one are kept; the hidden one is implicit.
    always_comb begin
        n_frac   = in_mant[NW-1:0];
        n_sticky = 1'b0;
        n_exp    = exp_x;
        if (in_mant[PROD_W-1]) begin
            n_frac   = in_mant[PROD_W-2:1];
            n_sticky = in_mant[0];
            n_exp    = exp_x + XW'(1);
        end else if (!in_mant[PROD_W-2]) begin
            // Shifting out of an NW-wide field drops the leading one itself.
            n_frac = in_mant[NW-1:0] << lz;
            n_exp  = exp_x - XW'(lz);
        end
    end

    logic                 s1_vld;
    logic                 s1_sign;
    logic                 s1_zero;
    logic signed [XW-1:0] s1_exp;
    logic [NW-1:0]        s1_frac;
    logic                 s1_sticky;
    prec_t                s1_prec;
    logic                 s2_vld;
    logic                 s2_en;

    assign s2_en     = !s2_vld | out_ready;
    assign in_ready  = !s1_vld | s2_en;
    assign out_valid = s2_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld    <= 1'b0;
            s1_sign   <= 1'b0;
            s1_zero   <= 1'b0;
            s1_exp    <= '0;
            s1_frac   <= '0;
            s1_sticky <= 1'b0;
            s1_prec   <= PREC_7;
        end else if (in_ready) begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_sign   <= in_sign;
                s1_zero   <= n_zero;
                s1_exp    <= n_exp;
                s1_frac   <= n_frac;
                s1_sticky <= n_sticky;
                s1_prec   <= prec_t'(in_prec);
            end
        end
    end

    // ---------------- stage 2: round and pack ----------------
    int                     keep;
    int                     g_pos;
    logic [FW-1:0]          ext;
    logic                   g_bit;
    logic                   s_bit;
    logic                   rnd_up;
    logic [BF16_FRAC_W-1:0] frac_raw;
    logic [BF16_FRAC_W-1:0] unit;
    logic [BF16_FRAC_W-1:0] frac_tr;
    logic [BF16_FRAC_W:0]   sum;
    logic signed [XW-1:0]   exp_r;
    logic [15:0]            r_bf16;
    flags_t                 r_flags;

    always_comb begin
        keep     = int'(frac_keep(s1_prec));
        ext      = {s1_frac, s1_sticky};
        g_pos    = FW - 1 - keep;
        g_bit    = ext[g_pos];
        s_bit    = |(ext & ((ONE_F << g_pos) - ONE_F));
        frac_raw = ext[FW-1 -: BF16_FRAC_W];
        // unit is the weight of the lowest kept fraction bit.
        unit     = ONE_R << (BF16_FRAC_W - keep);
        frac_tr  = frac_raw & ~(unit - ONE_R);
`ifdef ROUND_RNE_EN
        rnd_up   = g_bit & (s_bit | ext[g_pos+1]);
`else
        rnd_up   = 1'b0;
`endif
        // A carry into sum's top bit means the hidden one overflowed to 2.0;
        // the fraction bits are already zero in that case.
        sum      = {1'b0, frac_tr} + (rnd_up ? {1'b0, unit} : '0);
        exp_r    = s1_exp + XW'(sum[BF16_FRAC_W]);

        r_flags  = '0;
        r_bf16   = {s1_sign, exp_r[7:0], sum[BF16_FRAC_W-1:0]};
        if (s1_zero) begin
            r_bf16 = {s1_sign, 15'h0000};
        end else if (exp_r >= EXP_MAX_X) begin
            r_bf16  = {s1_sign, 8'hFF, 7'h00};
            r_flags = '{ovf: 1'b1, unf: 1'b0, inx: 1'b1};
        end else if (exp_r <= ZERO_X) begin
            r_bf16  = {s1_sign, 15'h0000};
            r_flags = '{ovf: 1'b0, unf: 1'b1, inx: 1'b1};
        end else begin
            r_flags.inx = g_bit | s_bit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld    <= 1'b0;
            out_bf16  <= '0;
            out_flags <= '0;
        end else if (s2_en) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                out_bf16  <= r_bf16;
                out_flags <= r_flags;
            end
        end
    end

endmodule
